divider: RTL and testbench



---
 rtl/divider.sv | 225 ++++++++++++++++++++++
 tb/tb_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Sequential signed 32-bit integer divider using a non-restoring radix-2
//   algorithm. It produces one quotient bit per clock and uses a start/done
//   handshake. The result packs the remainder into the upper word and the
//   quotient into the lower word, which is the same HI/LO layout as the
//   multiplier's 64-bit product.
//
//   Handshake: a request is accepted on the rising edge where start=1 and the
//   FSM is in IDLE. The operands are captured on that edge only. start is
//   ignored while a division is in flight. done is a single-cycle pulse.
//   out and div_zero become valid on the edge that raises done, and they hold
//   until the next done. busy covers acceptance through the done cycle,
//   including the done cycle itself.
//
//   Latency from the accepting edge E0 to done:
//     normal        : done is high after E34 (load, 32 x CALC, FIX, DONE).
//     zero divisor  : done is high after E1 (only with DIVIDER_ZERO_CHECK_EN).
//
//   Optional feature (macro DIVIDER_ZERO_CHECK_EN):
//     defined   - A zero divisor skips the iterations. The result is
//                 out = {dividend, 32'hFFFFFFFF} and div_zero = 1.
//     undefined - There is no zero detection and div_zero is tied to 0.
//                 A zero divisor runs the full sequence.
//
//   Ports:
//     clk       in   1   rising-edge clock
//     clr_n     in   1   asynchronous active-low reset
//     start     in   1   division request, sampled in IDLE
//     dividend  in  32   signed numerator
//     divisor   in  32   signed denominator
//     busy      out  1   division in progress (through the done cycle)
//     done      out  1   one-cycle result strobe
//     out       out 64   {remainder, quotient}
//     div_zero  out  1   the result on out came from a zero divisor
//
//   The FSM state is observable as state_q (type divider.state_t).
// -----------------------------------------------------------------------------
module divider (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] out,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [32:0] rem_q,   rem_d;     // signed partial remainder
    logic [31:0] quo_q,   quo_d;     // dividend magnitude shifting out, quotient shifting in
    logic [32:0] dvs_q,   dvs_d;     // divisor magnitude; 33 bits so that 2^31 fits
    logic        sa_q,    sa_d;      // dividend sign
    logic        sb_q,    sb_d;      // divisor sign
    logic [4:0]  cnt_q,   cnt_d;     // iteration counter
    logic [63:0] out_q,   out_d;
    logic        done_q,  done_d;

`ifdef DIVIDER_ZERO_CHECK_EN
    logic        zero_q,  zero_d;    // the request in flight had a zero divisor
    logic        dz_q,    dz_d;
`endif

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_sh;
    logic [32:0] rem_new;
    logic [31:0] q_signed;
    logic [31:0] r_signed;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    always_comb begin
        // The magnitude of -2^31 is 2^31. That value is still exact when it is
        // read as unsigned 32-bit.
        a_mag    = dividend[31] ? (32'd0 - dividend) : dividend;
        b_mag    = divisor[31]  ? (32'd0 - divisor)  : divisor;

        // Shift {R,Q} left by one. R stays within (-2D, 2D), so dropping the
        // old R[32] keeps its sign: the old R[31] becomes the new sign bit.
        rem_sh   = {rem_q[31:0], quo_q[31]};
        rem_new  = rem_q[32] ? (rem_sh + dvs_q) : (rem_sh - dvs_q);

        // Apply the operand signs. Results wrap mod 2^32, so
        // 0x80000000 / -1 gives 0x80000000.
        q_signed = (sa_q ^ sb_q) ? (32'd0 - quo_q) : quo_q;
        r_signed = sa_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    end

    // -------------------------------------------------------------------------
    // Next-state / next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
        zero_d  = zero_q;
        dz_d    = dz_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = dividend[31];
                    sb_d    = divisor[31];
                    quo_d   = a_mag;
                    dvs_d   = {1'b0, b_mag};
                    rem_d   = 33'd0;
                    cnt_d   = 5'd0;
                    state_d = CALC;
`ifdef DIVIDER_ZERO_CHECK_EN
                    zero_d  = 1'b0;
                    if (divisor == 32'd0) begin
                        // Park the raw dividend so that DONE can present it.
                        zero_d  = 1'b1;
                        quo_d   = dividend;
                        state_d = DONE;
                    end
`endif
                end
            end

            CALC: begin
                rem_d = rem_new;
                quo_d = {quo_q[30:0], ~rem_new[32]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // A negative final remainder is restored once. The quotient
                // bits are already correct.
                if (rem_q[32]) begin
                    rem_d = rem_q + dvs_q;
                end
                state_d = DONE;
            end

            DONE: begin
                done_d  = 1'b1;
                out_d   = {r_signed, q_signed};
`ifdef DIVIDER_ZERO_CHECK_EN
                dz_d    = zero_q;
                if (zero_q) begin
                    out_d = {quo_q, 32'hFFFF_FFFF};
                end
`endif
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            rem_q   <= 33'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 33'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= 5'd0;
            out_q   <= 64'd0;
            done_q  <= 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
`ifdef DIVIDER_ZERO_CHECK_EN
            zero_q  <= zero_d;
            dz_q    <= dz_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The done pulse falls in a cycle where the FSM is already back in IDLE,
    // so busy has to include done_q.
    assign busy = (state_q != IDLE) || done_q;
    assign done = done_q;
    assign out  = out_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Directed testbench for the divider. It uses hand-computed expected results.
//   Drivers push the expected {div_zero, out} value and the expected done
//   cycle into queues. A monitor compares them whenever done is seen.
// -----------------------------------------------------------------------------
module tb_divider;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] out;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [64:0] exp_q[$];      // {div_zero, out}
    int          exp_cyc_q[$];  // cycle count at which done must be seen

    divider dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .div_zero (div_zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (clr_n && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                logic [64:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("out", out, e[63:0]);
                check("div_zero", {63'd0, div_zero}, {63'd0, e[64]});
                check("done_latency", 64'(cyc), 64'(ec));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    // Launch one division and follow it until done drops. lat is the number of
    // edges after the accepting edge before done is high (34 or 1).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_out, input logic exp_dz, input int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back({exp_dz, exp_out});
        exp_cyc_q.push_back(cyc + 1 + lat);
        @(negedge clk);
        start    = 1'b0;
        // Operand changes after acceptance have to be ignored.
        dividend = $urandom;
        divisor  = $urandom_range(1, 1000);
        check("busy_after_start", {63'd0, busy}, 64'd1);
        wait_done(lat + 5);
        check("busy_in_done", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        clr_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_out", out, 64'd0);
        check("reset_div_zero", {63'd0, div_zero}, 64'd0);
        @(negedge clk);
        clr_n = 1'b1;

        // Directed vectors: out = {remainder, quotient}.
        run_div(32'd100,         32'd7,          {32'd2,          32'd14},         1'b0, 34);
        run_div(-32'sd100,       32'd7,          {32'hFFFFFFFE,   32'hFFFFFFF2},   1'b0, 34);
        run_div(32'd100,         -32'sd7,        {32'd2,          32'hFFFFFFF2},   1'b0, 34);
        run_div(-32'sd100,       -32'sd7,        {32'hFFFFFFFE,   32'd14},         1'b0, 34);
        run_div(32'h80000000,    32'hFFFFFFFF,   {32'd0,          32'h80000000},   1'b0, 34);
        run_div(32'h7FFFFFFF,    32'd1,          {32'd0,          32'h7FFFFFFF},   1'b0, 34);
        run_div(32'h80000000,    32'h80000000,   {32'd0,          32'd1},          1'b0, 34);
        run_div(32'd5,           32'd100,        {32'd5,          32'd0},          1'b0, 34);
        run_div(32'd0,           32'd5,          {32'd0,          32'd0},          1'b0, 34);
        run_div(32'hFFFFFFFF,    32'd2,          {32'hFFFFFFFF,   32'd0},          1'b0, 34);
`ifdef DIVIDER_ZERO_CHECK_EN
        run_div(32'd1234,        32'd0,          {32'd1234,       32'hFFFFFFFF},   1'b1, 1);
`endif
        run_div(32'd10,          32'd3,          {32'd1,          32'd3},          1'b0, 34);

        // A second start pulse during an active division is ignored. out holds
        // the previous result {1,3} until the new done.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        exp_q.push_back({1'b0, 32'd2, 32'd14});
        exp_cyc_q.push_back(cyc + 1 + 34);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check("out_held", out, {32'd1, 32'd3});
        wait_done(40);
        @(negedge clk);
        repeat (40) @(negedge clk);   // any second done would be caught by the monitor

        // Back-to-back: start stays high and the next request is taken on the
        // edge that closes the done cycle.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd10;
        divisor  = 32'd3;
        exp_q.push_back({1'b0, 32'd1, 32'd3});
        exp_cyc_q.push_back(cyc + 1 + 34);
        wait_done(40);
        k = cyc;
        dividend = 32'd45;
        divisor  = 32'd6;
        exp_q.push_back({1'b0, 32'd3, 32'd7});
        exp_cyc_q.push_back(k + 1 + 34);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(40);
        @(negedge clk);

        // Asynchronous reset during CALC discards the in-flight result.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("clr_busy", {63'd0, busy}, 64'd0);
        check("clr_done", {63'd0, done}, 64'd0);
        check("clr_out", out, 64'd0);
        check("clr_div_zero", {63'd0, div_zero}, 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        run_div(32'd45, 32'd6, {32'd3, 32'd7}, 1'b0, 34);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
